// File: rtl/aes_multi_channel_sched.sv
// Round-robin front end that time-shares one iterative AES-128 core among NCH channels,
// with a per-channel result slot and a sticky per-channel core-timeout flag.
module aes_multi_channel_sched #(
    parameter int NCH     = 4,
    parameter int KW      = 128,
    parameter int DW      = 128,
    parameter int TIMEOUT = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    in_valid,
    output logic [NCH-1:0]    in_ready,
    input  logic [NCH*KW-1:0] in_key,
    input  logic [NCH*DW-1:0] in_text,
    output logic [NCH-1:0]    out_valid,
    input  logic [NCH-1:0]    out_ready,
    output logic [NCH*DW-1:0] out_data,
    output logic              core_ld,
    output logic [KW-1:0]     core_key,
    output logic [DW-1:0]     core_text,
    input  logic              core_done,
    input  logic [DW-1:0]     core_dout,
    output logic              busy,
    output logic [NCH-1:0]    err,
    input  logic              err_clr
);

    localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        BUSY
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   gidx;
    logic [PW-1:0]   grant_idx;
    logic            grant_found;
    logic [CW-1:0]   cnt;
    logic            timeout_hit;

    assign timeout_hit = (cnt == CW'(TIMEOUT - 1));

    // A channel with a full result slot is skipped so a completion always has somewhere to land.
    always_comb begin
        int            idx;
        logic [PW-1:0] cand;
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        cand        = '0;
        for (int i = 0; i < NCH; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NCH) begin
                idx = idx - NCH;
            end
            cand = PW'(idx);
            if (!grant_found && in_valid[cand] && !out_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = '0;
        core_ld    = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (rst && grant_found) begin
                    in_ready[grant_idx] = 1'b1;
                    state_next          = ISSUE;
                end
            end
            ISSUE: begin
                core_ld    = 1'b1;
                state_next = BUSY;
            end
            BUSY: begin
                if (core_done || timeout_hit) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A done arriving on the last allowed cycle still counts as success.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr    <= '0;
            gidx      <= '0;
            cnt       <= '0;
            core_key  <= '0;
            core_text <= '0;
            out_valid <= '0;
            out_data  <= '0;
            err       <= '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (out_valid[c] && out_ready[c]) begin
                    out_valid[c] <= 1'b0;
                end
            end
            if (err_clr) begin
                err <= '0;
            end
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        gidx      <= grant_idx;
                        core_key  <= in_key[int'(grant_idx)*KW +: KW];
                        core_text <= in_text[int'(grant_idx)*DW +: DW];
                        rr_ptr    <= (int'(grant_idx) == NCH - 1) ? '0 : grant_idx + PW'(1);
                    end
                end
                ISSUE: begin
                    cnt <= '0;
                end
                BUSY: begin
                    cnt <= cnt + CW'(1);
                    if (core_done) begin
                        out_data[int'(gidx)*DW +: DW] <= core_dout;
                        out_valid[gidx]               <= 1'b1;
                    end else if (timeout_hit) begin
                        err[gidx] <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_multi_channel_sched.sv
// Scoreboard bench for aes_multi_channel_sched: a behavioural core answers core_ld, expected
// results are queued per channel at grant time and checked when the channel pops its slot.
module tb_aes_multi_channel_sched;

    localparam int NCH     = 4;
    localparam int KW      = 128;
    localparam int DW      = 128;
    localparam int TIMEOUT = 32;

    logic              clk       = 1'b0;
    logic              rst       = 1'b0;
    logic [NCH-1:0]    in_valid;
    logic [NCH-1:0]    in_ready;
    logic [NCH*KW-1:0] in_key;
    logic [NCH*DW-1:0] in_text;
    logic [NCH-1:0]    out_valid;
    logic [NCH-1:0]    out_ready = '1;
    logic [NCH*DW-1:0] out_data;
    logic              core_ld;
    logic [KW-1:0]     core_key;
    logic [DW-1:0]     core_text;
    logic              core_done = 1'b0;
    logic [DW-1:0]     core_dout = '0;
    logic              busy;
    logic [NCH-1:0]    err;
    logic              err_clr   = 1'b0;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [127:0] base_key  [NCH];
    logic [127:0] base_text [NCH];
    int           req_total    [NCH] = '{default: 0};
    int           req_done     [NCH] = '{default: 0};
    int           discard_req  [NCH] = '{default: 0};
    int           discard_done [NCH] = '{default: 0};
    logic [127:0] exp_q [NCH][$];
    int           grant_log[$];

    int           core_lat   = 3;
    int           spur_cnt   = 0;
    int           spur_seen  = 0;
    bit           pending    = 1'b0;
    int           remaining  = 0;
    logic [127:0] mk         = '0;
    logic [127:0] mt         = '0;

    aes_multi_channel_sched #(
        .NCH     (NCH),
        .KW      (KW),
        .DW      (DW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_key    (in_key),
        .in_text   (in_text),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .core_ld   (core_ld),
        .core_key  (core_key),
        .core_text (core_text),
        .core_done (core_done),
        .core_dout (core_dout),
        .busy      (busy),
        .err       (err),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    // Stand-in for the AES core: the FIPS-197 vector maps to its real ciphertext, anything else to a keyed mix.
    function automatic logic [127:0] model_f(input logic [127:0] k, input logic [127:0] t);
        if (k == 128'h000102030405060708090a0b0c0d0e0f && t == 128'h00112233445566778899aabbccddeeff) begin
            return 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        end
        return k ^ {t[63:0], t[127:64]} ^ 128'h5a5a_c3c3_0f0f_9696_a5a5_3c3c_f0f0_6969;
    endfunction

    task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input int c, input int n);
        req_total[c] = req_total[c] + n;
    endtask

    task automatic drain(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 1000 && !ok; i++) begin
            @(negedge clk);
            ok = !busy && (out_valid == '0);
            for (int c = 0; c < NCH; c++) begin
                if (req_done[c] != req_total[c] || exp_q[c].size() != 0) begin
                    ok = 1'b0;
                end
            end
        end
        check_output({name, "_drained"}, 128'(ok), 128'd1);
    endtask

    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            in_valid[c]         = (req_total[c] > req_done[c]);
            in_key[c*KW +: KW]  = base_key[c];
            in_text[c*DW +: DW] = base_text[c] + 128'(req_done[c]);
        end
    end

    always @(negedge clk) begin : core_model
        core_done = 1'b0;
        if (spur_seen != spur_cnt) begin
            spur_seen = spur_cnt;
            core_done = 1'b1;
            core_dout = 128'hdead_beef_dead_beef_dead_beef_dead_beef;
        end else if (core_ld) begin
            if (core_lat > 0) begin
                pending   = 1'b1;
                remaining = core_lat;
                mk        = core_key;
                mt        = core_text;
            end
        end else if (pending) begin
            remaining--;
            if (remaining == 0) begin
                core_done = 1'b1;
                core_dout = model_f(mk, mt);
                pending   = 1'b0;
            end
        end
    end

    // Pushes the expected result at each grant and checks it when the channel pops its slot.
    always begin : scoreboard
        logic [NCH-1:0] took;
        logic [127:0]   exp_v;
        @(negedge clk);
        took = '0;
        for (int c = 0; c < NCH; c++) begin
            if (discard_done[c] != discard_req[c]) begin
                exp_q[c].delete();
                discard_done[c] = discard_req[c];
            end
            if (rst && out_valid[c] && out_ready[c]) begin
                if (exp_q[c].size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("[TB] FAIL sb_ch%0d_unexpected: got %h required none", c, out_data[c*DW +: DW]);
                end else begin
                    exp_v = exp_q[c].pop_front();
                    check_output($sformatf("sb_ch%0d_data", c), out_data[c*DW +: DW], exp_v);
                end
            end
            if (rst && in_valid[c] && in_ready[c]) begin
                exp_q[c].push_back(model_f(base_key[c], base_text[c] + 128'(req_done[c])));
                grant_log.push_back(c);
                took[c] = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        for (int c = 0; c < NCH; c++) begin
            if (took[c]) begin
                req_done[c]++;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: got timeout required finish");
        $fatal(1, "[TB] simulation hung");
    end

    initial begin : main
        int ld_cyc;
        int ev_cyc;
        int n_ld;
        int viol;
        int gl0;
        int g;
        int left;

        for (int c = 0; c < NCH; c++) begin
            base_key[c]  = {32{4'(c + 1)}};
            base_text[c] = {32{4'(c + 8)}};
        end
        base_key[0]  = 128'h000102030405060708090a0b0c0d0e0f;
        base_text[0] = 128'h00112233445566778899aabbccddeeff;

        repeat (3) tick();
        @(negedge clk);
        check_output("rst_in_ready",  128'(in_ready),  128'd0);
        check_output("rst_out_valid", 128'(out_valid), 128'd0);
        check_output("rst_out_data",  128'(out_data[127:0] | out_data[511:384]), 128'd0);
        check_output("rst_core_ld",   128'(core_ld),   128'd0);
        check_output("rst_core_key",  core_key,        128'd0);
        check_output("rst_core_text", core_text,       128'd0);
        check_output("rst_busy",      128'(busy),      128'd0);
        check_output("rst_err",       128'(err),       128'd0);
        tick();
        rst = 1'b1;

        // Single request with the FIPS-197 vector
        tick();
        core_lat = 11;
        apply_stimulus(0, 1);
        ld_cyc = -1;
        ev_cyc = -1;
        n_ld   = 0;
        for (int i = 0; i < 100 && ev_cyc < 0; i++) begin
            @(negedge clk);
            if (core_ld) begin
                n_ld++;
                ld_cyc = i;
            end
            if (out_valid[0]) begin
                ev_cyc = i;
            end
        end
        check_output("t1_ld_count", 128'(n_ld), 128'd1);
        check_output("t1_ld_to_valid", 128'(ev_cyc - ld_cyc), 128'd12);
        drain("t1");

        // Fairness from a fresh reset
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        gl0 = grant_log.size();
        core_lat = 3;
        for (int c = 0; c < NCH; c++) begin
            apply_stimulus(c, 2);
        end
        drain("t2");
        for (int i = 0; i < 8; i++) begin
            g = (grant_log.size() > gl0 + i) ? grant_log[gl0 + i] : -1;
            check_output($sformatf("t2_grant%0d", i), 128'(g), 128'(i % 4));
        end

        // Backpressure on channel 1
        tick();
        out_ready[1] = 1'b0;
        apply_stimulus(1, 1);
        ev_cyc = -1;
        for (int i = 0; i < 100 && ev_cyc < 0; i++) begin
            @(negedge clk);
            if (out_valid[1]) begin
                ev_cyc = i;
            end
        end
        check_output("t3_slot_full", 128'(out_valid[1]), 128'd1);
        gl0 = grant_log.size();
        tick();
        apply_stimulus(1, 1);
        apply_stimulus(2, 1);
        viol = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (in_ready[1]) begin
                viol++;
            end
        end
        check_output("t3_ch1_blocked", 128'(viol), 128'd0);
        check_output("t3_grant_count", 128'(grant_log.size() - gl0), 128'd1);
        g = (grant_log.size() > gl0) ? grant_log[gl0] : -1;
        check_output("t3_ch2_served", 128'(g), 128'd2);
        tick();
        out_ready[1] = 1'b1;
        @(negedge clk);
        check_output("t3_pop_cycle_ready", 128'(in_ready[1]), 128'd0);
        tick();
        @(negedge clk);
        check_output("t3_after_pop_ready", 128'(in_ready[1]), 128'd1);
        drain("t3");

        // Core never answers: timeout on channel 3
        tick();
        core_lat = 0;
        apply_stimulus(3, 1);
        ld_cyc = -1;
        ev_cyc = -1;
        for (int i = 0; i < 100 && ev_cyc < 0; i++) begin
            @(negedge clk);
            if (core_ld) begin
                ld_cyc = i;
            end
            if (err[3]) begin
                ev_cyc = i;
            end
        end
        check_output("t4_ld_to_err", 128'(ev_cyc - ld_cyc), 128'd33);
        check_output("t4_no_result", 128'(out_valid[3]), 128'd0);
        check_output("t4_idle", 128'(busy), 128'd0);
        discard_req[3]++;
        tick();
        core_lat = 5;
        apply_stimulus(0, 1);
        drain("t4");
        check_output("t4_err_sticky", 128'(err), 128'h8);
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        @(negedge clk);
        check_output("t4_err_cleared", 128'(err), 128'd0);

        // Done on the last allowed cycle, then a spurious done while idle
        tick();
        core_lat = TIMEOUT;
        apply_stimulus(2, 1);
        drain("t5_boundary");
        check_output("t5_boundary_err", 128'(err), 128'd0);
        tick();
        spur_cnt++;
        n_ld = 0;
        viol = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (core_ld) begin
                n_ld++;
            end
            if (busy || out_valid != '0) begin
                viol++;
            end
        end
        check_output("t5_spur_ld", 128'(n_ld), 128'd0);
        check_output("t5_spur_effect", 128'(viol), 128'd0);

        // Reset while BUSY
        tick();
        core_lat = 20;
        apply_stimulus(1, 1);
        ev_cyc = -1;
        for (int i = 0; i < 50 && ev_cyc < 0; i++) begin
            @(negedge clk);
            if (core_ld) begin
                ev_cyc = i;
            end
        end
        check_output("t6_ld_seen", 128'(ev_cyc >= 0), 128'd1);
        repeat (3) tick();
        check_output("t6_busy_before", 128'(busy), 128'd1);
        rst = 1'b0;
        #1;
        check_output("t6_busy",      128'(busy),      128'd0);
        check_output("t6_core_key",  core_key,        128'd0);
        check_output("t6_core_text", core_text,       128'd0);
        check_output("t6_out_valid", 128'(out_valid), 128'd0);
        check_output("t6_out_data",  128'(out_data[255:128] | out_data[383:256]), 128'd0);
        check_output("t6_in_ready",  128'(in_ready),  128'd0);
        tick();
        rst = 1'b1;
        discard_req[1]++;
        viol = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy || out_valid != '0) begin
                viol++;
            end
        end
        check_output("t6_late_done_ignored", 128'(viol), 128'd0);
        gl0 = grant_log.size();
        core_lat = 4;
        tick();
        apply_stimulus(2, 1);
        apply_stimulus(1, 1);
        drain("t6");
        g = (grant_log.size() > gl0) ? grant_log[gl0] : -1;
        check_output("t6_rr_restart", 128'(g), 128'd1);

        left = 0;
        for (int c = 0; c < NCH; c++) begin
            left += exp_q[c].size();
        end
        check_output("final_queue_empty", 128'(left), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
